// File: rtl/rmt_ingress_arbiter.sv
// rtl/rmt_ingress_arbiter.sv - packet-granular ctrl/data AXIS merge with a registered output stage
// Define RMT_ARB_STATS_EN to add packet counters and the data-wait high-water mark.
module rmt_ingress_arbiter #(
  parameter int C_S_AXIS_DATA_WIDTH  = 512,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int CTRL_MAX_BURST       = 4
) (
  input  logic                              clk,
  input  logic                              aresetn,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_data_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_data_axis_tkeep,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_data_axis_tuser,
  input  logic                              s_data_axis_tvalid,
  input  logic                              s_data_axis_tlast,
  output logic                              s_data_axis_tready,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_ctrl_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_ctrl_axis_tkeep,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_ctrl_axis_tuser,
  input  logic                              s_ctrl_axis_tvalid,
  input  logic                              s_ctrl_axis_tlast,
  output logic                              s_ctrl_axis_tready,
  output logic [C_S_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                              m_axis_tvalid,
  output logic                              m_axis_tlast,
  input  logic                              m_axis_tready,
`ifdef RMT_ARB_STATS_EN
  output logic [31:0]                       ctrl_pkt_cnt,
  output logic [31:0]                       data_pkt_cnt,
  output logic [15:0]                       data_wait_max,
  output logic                              grant_ctrl
`else
  output logic                              grant_ctrl
`endif
);

  localparam int KW = C_S_AXIS_DATA_WIDTH / 8;
  localparam logic [3:0] MAX_BURST = 4'(CTRL_MAX_BURST);

  typedef enum logic [1:0] {IDLE, OWN_CTRL, OWN_DATA} state_e;

  state_e                            state_q, state_d;
  logic [3:0]                        burst_cnt_q, burst_cnt_d;
  logic                              m_tvalid_q, m_tvalid_d;
  logic                              m_tlast_q, m_tlast_d;
  logic [C_S_AXIS_DATA_WIDTH-1:0]    m_tdata_q, m_tdata_d;
  logic [KW-1:0]                     m_tkeep_q, m_tkeep_d;
  logic [C_S_AXIS_TUSER_WIDTH-1:0]   m_tuser_q, m_tuser_d;
  logic                              grant_q, grant_d;

  logic can_load, ctrl_sel, sel_ctrl, sel_data;
  logic ctrl_acc, data_acc, ctrl_done, data_done;

  assign can_load = !m_tvalid_q || m_axis_tready;
  assign ctrl_sel = s_ctrl_axis_tvalid && (!s_data_axis_tvalid || (burst_cnt_q < MAX_BURST));

  always_comb begin
    sel_ctrl = 1'b0;
    sel_data = 1'b0;
    case (state_q)
      IDLE: begin
        sel_ctrl = ctrl_sel;
        sel_data = !ctrl_sel && s_data_axis_tvalid;
      end
      OWN_CTRL: sel_ctrl = 1'b1;
      OWN_DATA: sel_data = 1'b1;
      default: begin
        sel_ctrl = 1'b0;
        sel_data = 1'b0;
      end
    endcase
  end

  // Gating with aresetn keeps both readys low for the whole reset, not just after the first edge.
  assign s_ctrl_axis_tready = aresetn && sel_ctrl && can_load;
  assign s_data_axis_tready = aresetn && sel_data && can_load;

  assign ctrl_acc  = s_ctrl_axis_tready && s_ctrl_axis_tvalid;
  assign data_acc  = s_data_axis_tready && s_data_axis_tvalid;
  assign ctrl_done = ctrl_acc && s_ctrl_axis_tlast;
  assign data_done = data_acc && s_data_axis_tlast;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (ctrl_acc && !s_ctrl_axis_tlast)      state_d = OWN_CTRL;
        else if (data_acc && !s_data_axis_tlast) state_d = OWN_DATA;
      end
      OWN_CTRL: if (ctrl_done) state_d = IDLE;
      OWN_DATA: if (data_done) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    burst_cnt_d = burst_cnt_q;
    if (data_done)
      burst_cnt_d = 4'd0;
    else if (ctrl_done && (burst_cnt_q < MAX_BURST))
      burst_cnt_d = burst_cnt_q + 4'd1;
  end

  always_comb begin
    m_tvalid_d = m_tvalid_q;
    m_tlast_d  = m_tlast_q;
    m_tdata_d  = m_tdata_q;
    m_tkeep_d  = m_tkeep_q;
    m_tuser_d  = m_tuser_q;
    if (ctrl_acc) begin
      m_tvalid_d = 1'b1;
      m_tlast_d  = s_ctrl_axis_tlast;
      m_tdata_d  = s_ctrl_axis_tdata;
      m_tkeep_d  = s_ctrl_axis_tkeep;
      m_tuser_d  = s_ctrl_axis_tuser;
    end else if (data_acc) begin
      m_tvalid_d = 1'b1;
      m_tlast_d  = s_data_axis_tlast;
      m_tdata_d  = s_data_axis_tdata;
      m_tkeep_d  = s_data_axis_tkeep;
      m_tuser_d  = s_data_axis_tuser;
    end else if (m_axis_tready) begin
      m_tvalid_d = 1'b0;
    end
  end

  // Stays high through ctrl-owned stalls and for the cycle that presents the last ctrl beat.
  assign grant_d = ctrl_acc || (state_q == OWN_CTRL);

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= IDLE;
      burst_cnt_q <= 4'd0;
      m_tvalid_q  <= 1'b0;
      m_tlast_q   <= 1'b0;
      m_tdata_q   <= '0;
      m_tkeep_q   <= '0;
      m_tuser_q   <= '0;
      grant_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      burst_cnt_q <= burst_cnt_d;
      m_tvalid_q  <= m_tvalid_d;
      m_tlast_q   <= m_tlast_d;
      m_tdata_q   <= m_tdata_d;
      m_tkeep_q   <= m_tkeep_d;
      m_tuser_q   <= m_tuser_d;
      grant_q     <= grant_d;
    end
  end

  assign m_axis_tvalid = m_tvalid_q;
  assign m_axis_tlast  = m_tlast_q;
  assign m_axis_tdata  = m_tdata_q;
  assign m_axis_tkeep  = m_tkeep_q;
  assign m_axis_tuser  = m_tuser_q;
  assign grant_ctrl    = grant_q;

`ifdef RMT_ARB_STATS_EN
  logic [31:0] ctrl_cnt_q, ctrl_cnt_d;
  logic [31:0] data_cnt_q, data_cnt_d;
  logic [15:0] wait_run_q, wait_run_d;
  logic [15:0] wait_max_q, wait_max_d;
  logic        data_waiting;

  assign data_waiting = s_data_axis_tvalid &&
                        ((state_q == OWN_CTRL) || ((state_q == IDLE) && ctrl_sel));

  always_comb begin
    ctrl_cnt_d = ctrl_cnt_q + {31'd0, ctrl_done};
    data_cnt_d = data_cnt_q + {31'd0, data_done};
    wait_run_d = 16'd0;
    if (data_waiting)
      wait_run_d = (wait_run_q == 16'hffff) ? wait_run_q : wait_run_q + 16'd1;
    wait_max_d = (wait_run_d > wait_max_q) ? wait_run_d : wait_max_q;
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      ctrl_cnt_q <= 32'd0;
      data_cnt_q <= 32'd0;
      wait_run_q <= 16'd0;
      wait_max_q <= 16'd0;
    end else begin
      ctrl_cnt_q <= ctrl_cnt_d;
      data_cnt_q <= data_cnt_d;
      wait_run_q <= wait_run_d;
      wait_max_q <= wait_max_d;
    end
  end

  assign ctrl_pkt_cnt  = ctrl_cnt_q;
  assign data_pkt_cnt  = data_cnt_q;
  assign data_wait_max = wait_max_q;
`endif

endmodule

// File: tb/tb_rmt_ingress_arbiter.sv
// tb/tb_rmt_ingress_arbiter.sv - vector table plus scoreboarded packet sequences for rmt_ingress_arbiter
// Stats checks compile in when RMT_ARB_STATS_EN is defined.
module tb_rmt_ingress_arbiter;

  logic          clk;
  logic          aresetn;
  logic [511:0]  s_data_axis_tdata, s_ctrl_axis_tdata, m_axis_tdata;
  logic [63:0]   s_data_axis_tkeep, s_ctrl_axis_tkeep, m_axis_tkeep;
  logic [127:0]  s_data_axis_tuser, s_ctrl_axis_tuser, m_axis_tuser;
  logic          s_data_axis_tvalid, s_data_axis_tlast, s_data_axis_tready;
  logic          s_ctrl_axis_tvalid, s_ctrl_axis_tlast, s_ctrl_axis_tready;
  logic          m_axis_tvalid, m_axis_tlast, m_axis_tready;
  logic          grant_ctrl;
`ifdef RMT_ARB_STATS_EN
  logic [31:0]   ctrl_pkt_cnt, data_pkt_cnt;
  logic [15:0]   data_wait_max;
`endif

  rmt_ingress_arbiter dut (
    .clk(clk), .aresetn(aresetn),
    .s_data_axis_tdata(s_data_axis_tdata), .s_data_axis_tkeep(s_data_axis_tkeep),
    .s_data_axis_tuser(s_data_axis_tuser), .s_data_axis_tvalid(s_data_axis_tvalid),
    .s_data_axis_tlast(s_data_axis_tlast), .s_data_axis_tready(s_data_axis_tready),
    .s_ctrl_axis_tdata(s_ctrl_axis_tdata), .s_ctrl_axis_tkeep(s_ctrl_axis_tkeep),
    .s_ctrl_axis_tuser(s_ctrl_axis_tuser), .s_ctrl_axis_tvalid(s_ctrl_axis_tvalid),
    .s_ctrl_axis_tlast(s_ctrl_axis_tlast), .s_ctrl_axis_tready(s_ctrl_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tuser(m_axis_tuser),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
`ifdef RMT_ARB_STATS_EN
    .ctrl_pkt_cnt(ctrl_pkt_cnt), .data_pkt_cnt(data_pkt_cnt), .data_wait_max(data_wait_max),
`endif
    .grant_ctrl(grant_ctrl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [511:0] tdata;
    logic [63:0]  tkeep;
    logic [127:0] tuser;
    logic         tlast;
    logic         grant;
  } beat_t;

  typedef struct {
    bit cv;
    bit dv;
    int win;  // 0 none, 1 ctrl, 2 data
  } vec_t;

  beat_t exp_q[$];
  int    n_pass = 0;
  int    n_total = 0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [511:0] mk_data(input bit is_ctrl, input logic [15:0] id, input int b);
    logic [511:0] d;
    d = '0;
    for (int i = 0; i < 16; i++)
      d[i*32 +: 32] = {id, 8'(b), 8'(i)} ^ (is_ctrl ? 32'h5a5a_0000 : 32'h0);
    if (is_ctrl && b == 0) d[303:288] = 16'hf2f1;
    return d;
  endfunction

  function automatic logic [63:0] mk_keep(input bit is_ctrl, input bit last);
    return (!is_ctrl && last) ? 64'h00000000000fffff : 64'hffffffffffffffff;
  endfunction

  function automatic logic [127:0] mk_user(input bit is_ctrl, input logic [15:0] id, input int b);
    return {id, 16'(b), 8'(is_ctrl), 88'h0};
  endfunction

  task automatic push_beat(input bit is_ctrl, input logic [15:0] id, input int b, input bit last);
    beat_t e;
    e.tdata = mk_data(is_ctrl, id, b);
    e.tkeep = mk_keep(is_ctrl, last);
    e.tuser = mk_user(is_ctrl, id, b);
    e.tlast = last;
    e.grant = is_ctrl;
    exp_q.push_back(e);
  endtask

  task automatic push_pkt(input bit is_ctrl, input logic [15:0] id, input int n);
    for (int b = 0; b < n; b++) push_beat(is_ctrl, id, b, b == n - 1);
  endtask

  task automatic set_src(input bit is_ctrl, input logic v, input logic [15:0] id, input int b,
                         input logic last);
    if (is_ctrl) begin
      s_ctrl_axis_tvalid = v;
      s_ctrl_axis_tdata  = mk_data(1'b1, id, b);
      s_ctrl_axis_tkeep  = mk_keep(1'b1, last);
      s_ctrl_axis_tuser  = mk_user(1'b1, id, b);
      s_ctrl_axis_tlast  = last;
    end else begin
      s_data_axis_tvalid = v;
      s_data_axis_tdata  = mk_data(1'b0, id, b);
      s_data_axis_tkeep  = mk_keep(1'b0, last);
      s_data_axis_tuser  = mk_user(1'b0, id, b);
      s_data_axis_tlast  = last;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the last beat is accepted.
  task automatic send_pkt(input bit is_ctrl, input logic [15:0] id, input int n);
    bit acc;
    int w;
    for (int b = 0; b < n; b++) begin
      set_src(is_ctrl, 1'b1, id, b, b == n - 1);
      acc = 1'b0;
      w = 0;
      while (!acc && w < 200) begin
        @(negedge clk);
        acc = is_ctrl ? s_ctrl_axis_tready : s_data_axis_tready;
        @(posedge clk);
        #1;
        w++;
      end
      if (!acc) begin
        n_total++;
        $display("FAIL send_timeout: src=%0d id=%0h beat=%0d not accepted in %0d cycles", is_ctrl, id, b, w);
      end
    end
    if (is_ctrl) s_ctrl_axis_tvalid = 1'b0;
    else         s_data_axis_tvalid = 1'b0;
  endtask

  always @(negedge clk) begin
    beat_t e;
    if (aresetn && m_axis_tvalid && m_axis_tready) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_beat: got tdata %0h expected no beat", m_axis_tdata);
      end else begin
        e = exp_q.pop_front();
        chk("beat_tdata", m_axis_tdata, e.tdata);
        chk("beat_last_grant_keep_user", {m_axis_tlast, grant_ctrl, m_axis_tkeep, m_axis_tuser},
            {e.tlast, e.grant, e.tkeep, e.tuser});
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  vec_t vecs[13];
  int   cnt;

  initial begin
    vecs[0]  = '{1'b0, 1'b0, 0};
    vecs[1]  = '{1'b0, 1'b1, 2};
    vecs[2]  = '{1'b1, 1'b0, 1};
    vecs[3]  = '{1'b1, 1'b1, 1};
    vecs[4]  = '{1'b1, 1'b1, 1};
    vecs[5]  = '{1'b1, 1'b1, 1};
    vecs[6]  = '{1'b1, 1'b1, 2};
    vecs[7]  = '{1'b1, 1'b1, 1};
    vecs[8]  = '{1'b1, 1'b0, 1};
    vecs[9]  = '{1'b1, 1'b0, 1};
    vecs[10] = '{1'b1, 1'b0, 1};
    vecs[11] = '{1'b1, 1'b0, 1};
    vecs[12] = '{1'b1, 1'b1, 2};

    aresetn = 1'b0;
    m_axis_tready = 1'b1;
    set_src(1'b1, 1'b1, 16'hdead, 0, 1'b1);
    set_src(1'b0, 1'b1, 16'hbeef, 0, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_m_tvalid", m_axis_tvalid, 0);
    chk("rst_m_tlast", m_axis_tlast, 0);
    chk("rst_grant", grant_ctrl, 0);
    chk("rst_tdata", m_axis_tdata, 0);
    chk("rst_keep_user", {m_axis_tkeep, m_axis_tuser}, 0);
    chk("rst_treadys", {s_ctrl_axis_tready, s_data_axis_tready}, 0);
`ifdef RMT_ARB_STATS_EN
    chk("rst_stats", {ctrl_pkt_cnt, data_pkt_cnt, data_wait_max}, 0);
`endif
    s_ctrl_axis_tvalid = 1'b0;
    s_data_axis_tvalid = 1'b0;
    @(posedge clk);
    #1;
    aresetn = 1'b1;
    idle(1);

    // Single-beat arbitration vectors, walking burst_cnt up to saturation and back.
    for (int i = 0; i < 13; i++) begin
      logic [15:0] id;
      id = 16'h0100 + 16'(i);
      set_src(1'b1, vecs[i].cv, id, 0, 1'b1);
      set_src(1'b0, vecs[i].dv, id, 0, 1'b1);
      if (vecs[i].win == 1) push_pkt(1'b1, id, 1);
      else if (vecs[i].win == 2) push_pkt(1'b0, id, 1);
      @(negedge clk);
      chk($sformatf("vec%0d_treadys", i), {s_ctrl_axis_tready, s_data_axis_tready},
          {vecs[i].win == 1, vecs[i].win == 2});
      @(posedge clk);
      #1;
      s_ctrl_axis_tvalid = 1'b0;
      s_data_axis_tvalid = 1'b0;
      idle(1);
    end

    // Data-only 2-beat packet; ctrl must never see ready.
    push_pkt(1'b0, 16'h0200, 2);
    cnt = 0;
    fork
      send_pkt(1'b0, 16'h0200, 2);
      repeat (4) @(negedge clk) if (s_ctrl_axis_tready) cnt++;
    join
    idle(2);
    chk("dataonly_ctrl_tready_cycles", cnt, 0);

    // Concurrent start: ctrl wins, data follows, grant high for exactly 2 cycles.
    push_pkt(1'b1, 16'h0300, 2);
    push_pkt(1'b0, 16'h0301, 1);
    cnt = 0;
    fork
      send_pkt(1'b1, 16'h0300, 2);
      send_pkt(1'b0, 16'h0301, 1);
      repeat (6) @(negedge clk) if (grant_ctrl) cnt++;
    join
    idle(2);
    chk("concurrent_grant_cycles", cnt, 2);

    // Starvation bound: ctrl x4, data, ctrl x2.
    for (int k = 0; k < 4; k++) push_pkt(1'b1, 16'h0400 + 16'(k), 2);
    push_pkt(1'b0, 16'h04f0, 2);
    for (int k = 4; k < 6; k++) push_pkt(1'b1, 16'h0400 + 16'(k), 2);
    fork
      for (int k = 0; k < 6; k++) send_pkt(1'b1, 16'h0400 + 16'(k), 2);
      send_pkt(1'b0, 16'h04f0, 2);
    join
    idle(3);
    chk("starve_burst_after", dut.burst_cnt_q, 2);

    // Backpressure: m_axis_tready 1,0,0,1 during a 3-beat data packet.
    push_pkt(1'b0, 16'h0500, 3);
    fork
      send_pkt(1'b0, 16'h0500, 3);
      begin
        m_axis_tready = 1'b1;
        idle(1);
        m_axis_tready = 1'b0;
        @(negedge clk);
        chk("stall1_tdata", m_axis_tdata, mk_data(1'b0, 16'h0500, 0));
        chk("stall1_tvalid_dready", {m_axis_tvalid, s_data_axis_tready}, 2'b10);
        idle(1);
        @(negedge clk);
        chk("stall2_tdata", m_axis_tdata, mk_data(1'b0, 16'h0500, 0));
        chk("stall2_tvalid_dready", {m_axis_tvalid, s_data_axis_tready}, 2'b10);
        idle(1);
        m_axis_tready = 1'b1;
      end
    join
    idle(3);

    // Reset after beat 1 of a 3-beat ctrl packet.
    push_beat(1'b1, 16'h0600, 0, 1'b0);
    set_src(1'b1, 1'b1, 16'h0600, 0, 1'b0);
    @(negedge clk);
    idle(1);
    set_src(1'b1, 1'b1, 16'h0600, 1, 1'b0);
    @(negedge clk);
    #1;
    aresetn = 1'b0;
    #1;
    chk("midrst_tvalid_treadys_grant",
        {m_axis_tvalid, s_ctrl_axis_tready, s_data_axis_tready, grant_ctrl}, 0);
    s_ctrl_axis_tvalid = 1'b0;
    idle(2);
    aresetn = 1'b1;
    idle(1);
    push_pkt(1'b0, 16'h0610, 1);
    send_pkt(1'b0, 16'h0610, 1);
    idle(2);

    // Data waits 5 cycles behind a 5-beat ctrl packet, then two more ctrl packets.
    push_pkt(1'b1, 16'h0700, 5);
    push_pkt(1'b0, 16'h0701, 1);
    push_pkt(1'b1, 16'h0702, 1);
    push_pkt(1'b1, 16'h0703, 1);
    fork
      send_pkt(1'b1, 16'h0700, 5);
      send_pkt(1'b0, 16'h0701, 1);
    join
    send_pkt(1'b1, 16'h0702, 1);
    send_pkt(1'b1, 16'h0703, 1);
    idle(3);
`ifdef RMT_ARB_STATS_EN
    chk("stats_ctrl_pkt_cnt", ctrl_pkt_cnt, 3);
    chk("stats_data_pkt_cnt", data_pkt_cnt, 2);
    chk("stats_data_wait_max", data_wait_max, 5);
`endif

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
